// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
// Hold counter width and saturation value live here.
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam int ARB_HOLD_W = 8;
  localparam logic [ARB_HOLD_W-1:0] ARB_HOLD_MAX = '1;
endpackage

// File: rtl/rr_pick.sv
// Circular first-set-bit search starting at base.
// Rotates the request vector, then priority-encodes it.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  input  logic [ID_W-1:0] base,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [N-1:0]    rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0]   sum;

  always_comb begin
    rot   = N'({vec, vec} >> base);
    found = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = ID_W'(k);
      end
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (ID_W+1)'(N)) begin
      idx = ID_W'(sum - (ID_W+1)'(N));
    end else begin
      idx = sum[ID_W-1:0];
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant,
// bounded grant lock and idle-persistent fairness pointer.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  localparam logic [ARB_HOLD_W-1:0] HOLD_LIM =
    ARB_HOLD_W'(MAX_HOLD);

  arb_state_t            state_q, state_d;
  logic [N-1:0]          gnt_q, gnt_d;
  logic                  vld_q, vld_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [ARB_HOLD_W-1:0] hold_q, hold_d;

  logic [N-1:0]    others;
  logic [N-1:0]    pick_vec;
  logic [ID_W-1:0] base;
  logic            own_req, own_lock;
  logic            keep, grant_new;
  logic            found;
  logic [ID_W-1:0] idx;

  assign own_req  = req[id_q];
  assign own_lock = lock[id_q];
  assign others   = req & ~(N'(1) << id_q);
  assign base     = (last_q == ID_W'(N - 1)) ?
                    '0 : last_q + 1'b1;
  assign pick_vec = (state_q == ARB_IDLE) ? req : others;

  // Owner keeps: locked within budget, or sole requester.
  assign keep = (state_q == ARB_BUSY) && own_req &&
                (own_lock ?
                 ((others == '0) || (hold_q < HOLD_LIM)) :
                 (others == '0));
  assign grant_new = found && !keep;

  rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .vec   (pick_vec),
    .base  (base),
    .found (found),
    .idx   (idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      last_q  <= ID_W'(N - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (found) state_d = ARB_BUSY;
      ARB_BUSY: if (!keep && !found) state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    id_d   = id_q;
    last_d = last_q;
    hold_d = hold_q;
    unique case (1'b1)
      keep: begin
        gnt_d  = gnt_q;
        hold_d = (hold_q == ARB_HOLD_MAX) ?
                 hold_q : hold_q + 1'b1;
      end
      grant_new: begin
        gnt_d  = N'(1) << idx;
        id_d   = idx;
        last_d = idx;
        hold_d = ARB_HOLD_W'(1);
      end
      default: ;
    endcase
    vld_d = |gnt_d;
  end

  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;
  assign gnt_id    = id_q;

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised round-robin arbiter with registered one-hot grant, for N requesters sharing one resource. It is the next generation of the team's 4-requester round-robin FSM arbiter. New behaviour:
- any requester count
- a grant-lock (burst) input with a bounded hold time
- an encoded grant index alongside the one-hot grant
- fairness that survives idle periods

It sits in front of shared buses, memories and output ports.

## Interface
- `N`, default 4: number of requesters; legal range 2..32.
- `MAX_HOLD`, default 8: maximum consecutive cycles one locked grant may last while another requester is waiting; legal range 1..255.
- `ID_W`, default `$clog2(N)`: width of `gnt_id`; derived, never overridden.
- `clk` input 1: single clock; everything is on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req` input N: request per requester; level-sensitive.
- `lock` input N: `lock[i]` asks to keep the grant while `req[i]` stays high; ignored when `req[i]` is low.
- `gnt` output N: registered one-hot grant, or all-zero.
- `gnt_valid` output 1: registered; equals OR of `gnt`.
- `gnt_id` output `ID_W`: registered index of the granted requester; holds its last value while `gnt_valid` is 0.

## Operation
- FSM with two states:
  - `ARB_IDLE`: no grant.
  - `ARB_BUSY`: exactly one grant.
- `last` register (`ID_W`) holds the most recently granted index.
- `hold_cnt` register (8 bits) counts consecutive cycles of the current grant.
- Search order is `last+1`, `last+2`, …, `last+N`, taken modulo N. The current owner is therefore the lowest-priority candidate. `last` is not reset by idle periods.
- Next-state decision each cycle (current owner `g = gnt_id`, `others = req` with bit g cleared):
  - In `ARB_IDLE`: if `req` is 0, stay idle. Otherwise grant the first set bit in search order, go to `ARB_BUSY`, load `hold_cnt` = 1.
  - In `ARB_BUSY`, `req[g]` low: re-arbitrate over `others`. If `others` is 0, go to `ARB_IDLE`.
  - In `ARB_BUSY`, `req[g]` high, `lock[g]` high, and either `others` = 0 or `hold_cnt < MAX_HOLD`: keep g and increment `hold_cnt`. `hold_cnt` saturates at 255.
  - In `ARB_BUSY`, `req[g]` high, `lock[g]` low, and `others` = 0: keep g (sole requester) and increment `hold_cnt`.
  - In all other `ARB_BUSY` cases: grant the first set bit of `others` in search order and load `hold_cnt` = 1.
- On every new grant, `last` updates to the new index. `gnt` and `gnt_id` update in the same cycle.
- Unlocked and contended, each grant lasts exactly 1 cycle, giving a strict rotation.
- Locked and contended, a grant lasts at most `MAX_HOLD` cycles.
- Reset values:
  - state `ARB_IDLE`
  - `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0
  - `hold_cnt` = 0
  - `last` = N-1, so the first search starts at index 0
- Reset asserted mid-grant: the outputs clear on the next edge. No partial state survives.
- Invariants:
  - `gnt` is never multi-hot.
  - `gnt` is never set for a requester whose `req` was low in the deciding cycle.

## Timing
- Latency: `req` sampled at edge t produces `gnt` valid after edge t+1 (one register stage). There is no combinational path from inputs to outputs.
- Release: `req[g]` dropping in cycle t lets the next owner be granted after edge t+1. There is no dead cycle between owners.
- Lock expiry: with `lock[g]` held and another requester waiting, g's grant covers exactly `MAX_HOLD` cycles. The next requester is granted on cycle `MAX_HOLD`+1.
- Simultaneous events:
  - Release and new requests in the same cycle resolve in one decision.
  - `lock` rising on a cycle where g is already being pre-empted has no effect.
- Wrap-around: the search from `last` = N-1 continues at index 0.
- Starvation bound: any requester held high waits at most (N-1)·`MAX_HOLD` cycles.

## Structure
- Package `arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t`
  - constant `ARB_HOLD_W` = 8
- Sub-module `rr_pick`, combinational:
  - inputs: `vec[N]`, `base[ID_W]`
  - outputs: `found`, `idx[ID_W]`
  - behaviour: first set bit at or after `base`, modulo N, built as a rotate/priority-encode.
  - The top level instantiates it once and passes `base = last+1`, with `last+1` wrapping from N-1 to 0.

## Test plan
- Reset, then `req` = 4'b1111 with `lock` = 0 (N=4) → `gnt` sequence 0001, 0010, 0100, 1000, 0001; `gnt_id` 0, 1, 2, 3, 0, each lasting 1 cycle, first grant one cycle after `req`.
- `req` = 4'b0100 alone for 5 cycles, then 0 → `gnt` = 0100 for 5 cycles, then `gnt_valid` = 0. Next `req` = 4'b1111 → first grant 1000 (fairness preserved across idle).
- `MAX_HOLD` = 3, `req` = 4'b0011, `lock[0]` = 1 → `gnt` = 0001 for exactly 3 cycles, then 0010 for 1 cycle, then 0001 again.
- `lock[0]` = 1 with only `req[0]` high for 300 cycles → grant held throughout, `hold_cnt` saturates at 255 with no wrap.
- Reset pulsed while `gnt` = 0100 → next edge: `gnt` = 0, `gnt_id` = 0. After release with `req` = 4'b0110, `gnt` = 0010.
- N=5 randomised `req` and `lock` over 10k cycles → `gnt` always one-hot or zero, grant only to a requesting index, wait never exceeds 4·`MAX_HOLD`.
